segment_state_arbiter: RTL and testbench
========================================

# segment_state_arbiter

Owns the 1024-entry segment-state RAM (one on/off bit per LCD segment ID) and shares its single port between the mask pixel scanner, the CPU segment-update path and an internal clear sweep. The scanner issues fixed-latency lookups by segment ID and receives the live on/off bit. CPU writes use a valid/ready handshake. The block sits between the CPU LCD-output logic and the mask scanner, supplying the per-ID segment status the scanner needs.

## Interface
- SEGMENT_COUNT, 1024, number of segment IDs / RAM depth
- ID_WIDTH, 10, width of segment IDs ($clog2(SEGMENT_COUNT))

- clk  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- video_req  in  1  scanner lookup strobe, single cycle
- video_id  in  ID_WIDTH  segment ID to look up, sampled with video_req
- video_valid  out  1  lookup result valid
- video_enabled  out  1  segment on/off for the returned lookup
- cpu_wr_valid  in  1  CPU write request
- cpu_wr_ready  out  1  write accepted this cycle when valid && ready
- cpu_wr_id  in  ID_WIDTH  segment ID to write
- cpu_wr_value  in  1  new on/off value
- clear_req  in  1  pulse: zero all segment states
- busy  out  1  clear sweep in progress

## Operation
- States: CLEAR, IDLE. Reset forces CLEAR with sweep counter = 0.
- CLEAR: writes 0 to address = counter each cycle; counter increments. After address SEGMENT_COUNT-1 is written, the next state is IDLE. busy = 1 in CLEAR only.
- IDLE: port priority is video_req over CPU write.
  - video_req = 1: RAM read of video_id. cpu_wr_ready = 0.
  - Otherwise cpu_wr_ready = 1 and any valid write is performed.
- cpu_wr_ready is combinational: (state == IDLE) && !video_req. It does not depend on cpu_wr_valid.
- video_req in CLEAR: no RAM access. video_valid still pulses with the same latency, with video_enabled = 0.
- clear_req in IDLE: enter CLEAR with counter = 0 next cycle. A write accepted in the same cycle is still performed and then cleared.
- clear_req in CLEAR: counter restarts at 0.
- IDs ≥ SEGMENT_COUNT: writes are ignored but still accepted. Reads return 0.
- The counter is ID_WIDTH+1 bits so the terminal compare is exact; there is no wrap.

## Timing
- Reset values: video_valid = 0, video_enabled = 0, busy = 1 (the clear runs out of reset), cpu_wr_ready = 0.
- Video lookup latency: video_req at cycle N gives video_valid = 1 and video_enabled at cycle N+1 for one cycle.
- Video read-after-CPU-write: a write accepted at cycle N is visible to a video_req at cycle N+1 or later. A req at cycle N cannot coexist with a write at N.
- Clear duration: SEGMENT_COUNT cycles. busy falls at the first IDLE cycle, which is SEGMENT_COUNT cycles after the reset deassert or after the clear_req cycle.
- Throughput: the scanner issues at most one req per CLOCK_RATIO (≥ 2) cycles, so the CPU gets at least one write slot between lookups. No starvation counter is required.
- Reset mid-CLEAR or mid-lookup: the pending video_valid is dropped and the sweep restarts from 0.

## Structure
- Shared package segment_pkg: SEGMENT_COUNT, ID_WIDTH, and the state enum (CLEAR, IDLE).
- Sub-module segment_state_ram: 1-bit × SEGMENT_COUNT single-port synchronous RAM with a registered read. It has no reset and must infer block RAM.
- The arbiter holds the FSM, the sweep counter, the port mux and the video_valid pipeline register.

## Test plan
- Reset: hold reset 3 cycles, release → busy = 1 for exactly 1024 cycles, cpu_wr_ready = 0 during it. A video_req for ID 5 mid-sweep → video_valid next cycle with enabled = 0.
- CPU write then lookup: write ID 0x12A = 1 at cycle N, video_req ID 0x12A at N+1 → enabled = 1 at N+2. ID 0x12B reads 0.
- Collision: cpu_wr_valid held with ID 7 = 1 while video_req is pulsed every 4 cycles → ready is low only on req cycles, each write lands exactly once, and every lookup latency is 1.
- clear_req after writing IDs 0, 511 and 1023 = 1 → busy for 1024 cycles, then all three read 0. A second clear_req at sweep cycle 300 → busy extends to 1024 cycles from that pulse.
- Out-of-range: with SEGMENT_COUNT = 600, a write to ID 700 is accepted with no effect, a read of ID 700 returns 0, and ID 599 is read/writeable.
- Reset mid-sweep at cycle 500 → sweep restarts from 0, busy stays high for another 1024 cycles, and no stray video_valid appears.

Source files
------------

// File: rtl/segment_pkg.sv
// Shared constants and state encoding for the segment-state arbiter.
package segment_pkg;

  localparam int SEGMENT_COUNT = 1024;
  localparam int ID_WIDTH      = $clog2(SEGMENT_COUNT);

  // CLEAR sweeps the RAM to zero; IDLE serves scanner lookups and CPU writes.
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } seg_state_e;

endpackage

// File: rtl/segment_state_ram.sv
// 1-bit x DEPTH single-port synchronous RAM with a registered read.
// No reset on the array or read register so it maps onto block RAM.
module segment_state_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic          wdata,
  output logic          rdata
);

  logic mem [DEPTH];
  logic rdata_q;

  // Single port: write when we, registered read when re.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/segment_state_arbiter.sv
// Owns the segment-state RAM and shares its single port between the clear
// sweep, scanner lookups (priority) and CPU writes.
//
// CPU handshake: a write is taken on any cycle where cpu_wr_valid && cpu_wr_ready;
// cpu_wr_ready is high in IDLE whenever no scanner lookup is being issued and
// never depends on cpu_wr_valid.
module segment_state_arbiter
  import segment_pkg::*;
#(
  parameter int SEGMENT_COUNT = segment_pkg::SEGMENT_COUNT,
  parameter int ID_WIDTH      = $clog2(SEGMENT_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                video_req,
  input  logic [ID_WIDTH-1:0] video_id,
  output logic                video_valid,
  output logic                video_enabled,
  input  logic                cpu_wr_valid,
  output logic                cpu_wr_ready,
  input  logic [ID_WIDTH-1:0] cpu_wr_id,
  input  logic                cpu_wr_value,
  input  logic                clear_req,
  output logic                busy
);

  // Counter is one bit wider than an ID so the terminal compare never wraps.
  localparam logic [ID_WIDTH:0] SEG_LAST = (ID_WIDTH+1)'(SEGMENT_COUNT - 1);

  seg_state_e          state_q, state_d;
  logic [ID_WIDTH:0]   cnt_q, cnt_d;
  logic                vvalid_q, vvalid_d;
  logic                vhit_q, vhit_d;

  logic                ram_we, ram_re, ram_wdata, ram_rdata;
  logic [ID_WIDTH-1:0] ram_addr;
  logic                video_in_range, cpu_in_range;

  // IDs at or above SEGMENT_COUNT have no storage: reads give 0, writes drop.
  assign video_in_range = 32'(video_id)  < SEGMENT_COUNT;
  assign cpu_in_range   = 32'(cpu_wr_id) < SEGMENT_COUNT;

  // Next state, sweep counter and the RAM port mux.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    vvalid_d     = video_req;
    vhit_d       = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_wdata    = 1'b0;
    ram_addr     = '0;
    cpu_wr_ready = 1'b0;
    busy         = 1'b0;
    case (state_q)
      CLEAR: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        ram_addr = cnt_q[ID_WIDTH-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == SEG_LAST) state_d = IDLE;
        if (clear_req) begin
          cnt_d   = '0;
          state_d = CLEAR;
        end
      end
      IDLE: begin
        if (video_req) begin
          ram_re   = video_in_range;
          ram_addr = video_id;
          vhit_d   = video_in_range;
        end else begin
          cpu_wr_ready = 1'b1;
          if (cpu_wr_valid && cpu_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = cpu_wr_id;
            ram_wdata = cpu_wr_value;
          end
        end
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State, sweep counter and lookup pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      vvalid_q <= 1'b0;
      vhit_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vvalid_q <= vvalid_d;
      vhit_q   <= vhit_d;
    end
  end

  assign video_valid   = vvalid_q;
  assign video_enabled = vvalid_q & vhit_q & ram_rdata;

  segment_state_ram #(
    .DEPTH(SEGMENT_COUNT),
    .AW   (ID_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_segment_state_arbiter.sv
// Directed bench for segment_state_arbiter: default 1024-entry instance plus
// a 600-entry instance for the out-of-range cases.
module tb_segment_state_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no end, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT 1: 1024 entries ----------------
  logic       video_req = 1'b0;
  logic [9:0] video_id = '0;
  logic       video_valid, video_enabled;
  logic       cpu_wr_valid = 1'b0;
  logic       cpu_wr_ready;
  logic [9:0] cpu_wr_id = '0;
  logic       cpu_wr_value = 1'b0;
  logic       clear_req = 1'b0;
  logic       busy;

  segment_state_arbiter dut (
    .clk(clk), .reset(reset),
    .video_req(video_req), .video_id(video_id),
    .video_valid(video_valid), .video_enabled(video_enabled),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_id(cpu_wr_id), .cpu_wr_value(cpu_wr_value),
    .clear_req(clear_req), .busy(busy)
  );

  // ---------------- DUT 2: 600 entries ----------------
  logic       video_req2 = 1'b0;
  logic [9:0] video_id2 = '0;
  logic       video_valid2, video_enabled2;
  logic       cpu_wr_valid2 = 1'b0;
  logic       cpu_wr_ready2;
  logic [9:0] cpu_wr_id2 = '0;
  logic       cpu_wr_value2 = 1'b0;
  logic       clear_req2 = 1'b0;
  logic       busy2;

  segment_state_arbiter #(.SEGMENT_COUNT(600), .ID_WIDTH(10)) dut600 (
    .clk(clk), .reset(reset),
    .video_req(video_req2), .video_id(video_id2),
    .video_valid(video_valid2), .video_enabled(video_enabled2),
    .cpu_wr_valid(cpu_wr_valid2), .cpu_wr_ready(cpu_wr_ready2),
    .cpu_wr_id(cpu_wr_id2), .cpu_wr_value(cpu_wr_value2),
    .clear_req(clear_req2), .busy(busy2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [9:0] id, input logic val);
    cpu_wr_valid = 1'b1; cpu_wr_id = id; cpu_wr_value = val;
    #1;
    check_eq("wr_ready", cpu_wr_ready, 1);
    step();
    cpu_wr_valid = 1'b0;
  endtask

  task automatic lookup(input string tag, input logic [9:0] id, input logic exp);
    video_req = 1'b1; video_id = id;
    step();
    video_req = 1'b0;
    check_eq({tag, "_valid"}, video_valid, 1);
    check_eq({tag, "_en"}, video_enabled, {31'd0, exp});
  endtask

  task automatic lookup2(input string tag, input logic [9:0] id, input logic exp);
    video_req2 = 1'b1; video_id2 = id;
    step();
    video_req2 = 1'b0;
    check_eq({tag, "_valid"}, video_valid2, 1);
    check_eq({tag, "_en"}, video_enabled2, {31'd0, exp});
  endtask

  // Count busy cycles starting at the current sample point.
  task automatic count_busy(output int cnt, output int stray);
    cnt = 0; stray = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      if (video_valid !== 1'b0) stray++;
      cnt++;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt, cnt2, stray, rdy_err, acc;

    // Reset for 3 cycles.
    repeat (3) step();
    check_eq("rst_valid", video_valid, 0);
    check_eq("rst_en", video_enabled, 0);
    check_eq("rst_busy", busy, 1);
    check_eq("rst_ready", cpu_wr_ready, 0);

    // Release: sweep out of reset, lookup of ID 5 mid-sweep.
    reset = 1'b0;
    cnt = 0; cnt2 = 0; rdy_err = 0;
    while (busy === 1'b1 && cnt < 3000) begin
      if (cpu_wr_ready !== 1'b0) rdy_err++;
      if (busy2 === 1'b1) cnt2++;
      video_req = (cnt == 100);
      video_id  = 10'd5;
      cnt++;
      step();
      if (cnt == 101) begin
        check_eq("sweep_req_valid", video_valid, 1);
        check_eq("sweep_req_en", video_enabled, 0);
      end
    end
    video_req = 1'b0;
    check_eq("reset_busy_cycles", cnt, 1024);
    check_eq("sweep_ready_low", rdy_err, 0);
    check_eq("dut600_busy_cycles", cnt2, 600);
    #1;
    check_eq("idle_ready", cpu_wr_ready, 1);

    // CPU write then lookup on the next cycle.
    cpu_write(10'h12A, 1'b1);
    lookup("rd_12a", 10'h12A, 1'b1);
    lookup("rd_12b", 10'h12B, 1'b0);

    // Collision: write held, lookup every 4 cycles.
    cpu_wr_valid = 1'b1; cpu_wr_id = 10'd7; cpu_wr_value = 1'b1;
    rdy_err = 0; acc = 0;
    for (int i = 0; i < 16; i++) begin
      video_req = (i % 4 == 0);
      video_id  = 10'd7;
      #1;
      if (cpu_wr_ready !== !video_req) rdy_err++;
      if (cpu_wr_ready && cpu_wr_valid) acc++;
      step();
      check_eq("coll_valid", video_valid, (i % 4 == 0) ? 1 : 0);
      if (i % 4 == 0) check_eq("coll_en", video_enabled, (i == 0) ? 0 : 1);
    end
    cpu_wr_valid = 1'b0; video_req = 1'b0;
    check_eq("coll_ready_pattern", rdy_err, 0);
    check_eq("coll_accepted", acc, 12);

    // Clear after writing the extremes.
    cpu_write(10'd0, 1'b1);
    cpu_write(10'd511, 1'b1);
    cpu_write(10'd1023, 1'b1);
    lookup("pre_clr_0", 10'd0, 1'b1);
    lookup("pre_clr_511", 10'd511, 1'b1);
    lookup("pre_clr_1023", 10'd1023, 1'b1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    count_busy(cnt, stray);
    check_eq("clr_busy_cycles", cnt, 1024);
    lookup("post_clr_0", 10'd0, 1'b0);
    lookup("post_clr_511", 10'd511, 1'b0);
    lookup("post_clr_1023", 10'd1023, 1'b0);
    lookup("post_clr_7", 10'd7, 1'b0);

    // Second clear_req at sweep cycle 300 restarts the sweep.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (300) step();
    check_eq("restart_busy_before", busy, 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    count_busy(cnt, stray);
    check_eq("restart_busy_cycles", cnt, 1024);

    // Reset mid-sweep with a lookup pending.
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (500) step();
    reset = 1'b1; video_req = 1'b1; video_id = 10'd5;
    step();
    reset = 1'b0; video_req = 1'b0;
    check_eq("rst_mid_valid", video_valid, 0);
    count_busy(cnt, stray);
    check_eq("rst_mid_busy_cycles", cnt, 1024);
    check_eq("rst_mid_stray_valid", stray, 0);

    // Out-of-range IDs on the 600-entry instance.
    check_eq("d600_idle", busy2, 0);
    cpu_wr_valid2 = 1'b1; cpu_wr_id2 = 10'd700; cpu_wr_value2 = 1'b1;
    #1;
    check_eq("d600_wr700_ready", cpu_wr_ready2, 1);
    step();
    cpu_wr_valid2 = 1'b0;
    lookup2("d600_rd700", 10'd700, 1'b0);
    lookup2("d600_rd599_pre", 10'd599, 1'b0);
    cpu_wr_valid2 = 1'b1; cpu_wr_id2 = 10'd599; cpu_wr_value2 = 1'b1;
    #1;
    check_eq("d600_wr599_ready", cpu_wr_ready2, 1);
    step();
    cpu_wr_valid2 = 1'b0;
    lookup2("d600_rd599", 10'd599, 1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
